// File: rtl/alu_sequencer.sv
// alu_sequencer: one-command-at-a-time ALU with a 32-bit accumulator.
// Single-cycle ops answer the cycle after acceptance; mul/div/mod run a
// 16-step shift-add multiply or restoring divide before answering.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are
// both high. cmd_ready is high only in IDLE (and never during rst);
// rsp_valid is high only in RESP, where rsp_data/rsp_err hold steady until
// the rsp handshake, so a command can never share a cycle with a response.
module alu_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic               cmd_use_acc,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [2*WIDTH-1:0] rsp_data,
  output logic [1:0]         rsp_err,
  output logic               busy,
  output logic [1:0]         dbg_state
);
  localparam int W  = WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2,
                         OP_DIV = 4'd3, OP_MOD = 4'd4;

  typedef enum logic [1:0] {IDLE = 2'd0, ITER = 2'd1, RESP = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [W-1:0]    a_q, a_d;       // multiplicand, or dividend shifting into quotient
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [2*W-1:0]  prod_q, prod_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  data_q, data_d;
  logic [1:0]      err_q, err_d;

  logic [W-1:0]    opa;
  logic [W:0]      sum, diff;
  logic [2*W-1:0]  fast_res;
  logic [1:0]      fast_err;
  logic [2*W-1:0]  step_prod;
  logic [W:0]      rem_sh;
  logic [W-1:0]    step_rem, step_quo;
  logic            qbit;

  assign cmd_ready = (state_q == IDLE) && !rst;
  assign rsp_valid = (state_q == RESP);
  assign busy      = (state_q != IDLE);
  assign rsp_data  = data_q;
  assign rsp_err   = err_q;
  assign dbg_state = state_q;

  // Result of every op that finishes in one cycle, straight from the command.
  always_comb begin
    opa      = cmd_use_acc ? acc_q[W-1:0] : cmd_a;
    sum      = {1'b0, opa} + {1'b0, cmd_b};
    diff     = {1'b0, opa} - {1'b0, cmd_b};
    fast_res = '0;
    fast_err = 2'b00;
    case (cmd_op)
      4'd0:  begin fast_res = {{(W-1){1'b0}}, sum};       fast_err = {1'b0, sum[W]};  end
      4'd1:  begin fast_res = {{(W-1){diff[W]}}, diff};   fast_err = {1'b0, diff[W]}; end
      4'd5:  fast_res = {{W{1'b0}}, opa & cmd_b};
      4'd6:  fast_res = {{W{1'b0}}, opa | cmd_b};
      4'd7:  fast_res = {{W{1'b0}}, ~(opa & cmd_b)};
      4'd8:  fast_res = {{W{1'b0}}, ~(opa | cmd_b)};
      4'd9:  fast_res = {{W{1'b0}}, opa ^ cmd_b};
      4'd10: fast_res = {{W{1'b0}}, ~(opa ^ cmd_b)};
      4'd11: fast_res = {{W{1'b0}}, ~opa};
      4'd12: fast_res = {{W{1'b0}}, {W{1'b1}}};
      4'd14: fast_res = acc_q;
      4'd3, 4'd4, 4'd15: fast_err = 2'b10;   // div/mod reach here only with B==0
      default: fast_res = '0;                // zero (13); mul never takes this path
    endcase
  end

  // One step of shift-add multiply and of restoring divide.
  always_comb begin
    step_prod = prod_q + (b_q[cnt_q] ? ({{W{1'b0}}, a_q} << cnt_q) : '0);
    rem_sh    = {rem_q, a_q[W-1]};
    qbit      = (rem_sh >= {1'b0, b_q});
    step_rem  = qbit ? W'(rem_sh - {1'b0, b_q}) : rem_sh[W-1:0];
    step_quo  = {a_q[W-2:0], qbit};
  end

  // Next-state and datapath updates for IDLE -> (ITER) -> RESP -> IDLE.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rem_d   = rem_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          op_d   = cmd_op;
          a_d    = opa;
          b_d    = cmd_b;
          rem_d  = '0;
          prod_d = '0;
          cnt_d  = '0;
          if (cmd_op == OP_MUL || ((cmd_op == OP_DIV || cmd_op == OP_MOD) && cmd_b != '0)) begin
            state_d = ITER;
          end else begin
            state_d = RESP;
            data_d  = fast_res;
            err_d   = fast_err;
            if (fast_err == 2'b00) acc_d = fast_res;
          end
        end
      end
      ITER: begin
        cnt_d = cnt_q + 1'b1;
        if (op_q == OP_MUL) begin
          prod_d = step_prod;
        end else begin
          a_d   = step_quo;
          rem_d = step_rem;
        end
        if (cnt_q == LAST_STEP) begin
          state_d = RESP;
          err_d   = 2'b00;
          if (op_q == OP_MUL)      data_d = step_prod;
          else if (op_q == OP_DIV) data_d = {{W{1'b0}}, step_quo};
          else                     data_d = {{W{1'b0}}, step_rem};
          acc_d = data_d;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer: directed scenarios plus a randomized run
// checked against an arithmetic reference model of each opcode.
module tb_alu_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [15:0] cmd_a;
  logic [15:0] cmd_b;
  logic        cmd_use_acc;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_err;
  logic        busy;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [31:0] acc_m;   // reference accumulator

  alu_sequencer #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_acc(cmd_use_acc),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  // Reference: {err, data} from the arithmetic meaning of each opcode.
  function automatic logic [33:0] ref_result(input logic [3:0] op, input logic [15:0] a,
                                             input logic [15:0] b, input logic [31:0] acc);
    logic [31:0] d;
    logic [1:0]  e;
    d = 32'd0;
    e = 2'b00;
    case (op)
      4'd0:  begin d = 32'(a) + 32'(b); e[0] = (d > 32'hFFFF); end
      4'd1:  begin d = 32'(a) - 32'(b); e[0] = (a < b); end
      4'd2:  d = 32'(a) * 32'(b);
      4'd3:  if (b == 16'd0) e = 2'b10; else d = 32'(a / b);
      4'd4:  if (b == 16'd0) e = 2'b10; else d = 32'(a % b);
      4'd5:  d = {16'h0, a & b};
      4'd6:  d = {16'h0, a | b};
      4'd7:  d = {16'h0, ~(a & b)};
      4'd8:  d = {16'h0, ~(a | b)};
      4'd9:  d = {16'h0, a ^ b};
      4'd10: d = {16'h0, ~(a ^ b)};
      4'd11: d = {16'h0, ~a};
      4'd12: d = 32'h0000FFFF;
      4'd13: d = 32'd0;
      4'd14: d = acc;
      default: e = 2'b10;
    endcase
    return {e, d};
  endfunction

  function automatic int ref_latency(input logic [3:0] op, input logic [15:0] b);
    return (op == 4'd2 || ((op == 4'd3 || op == 4'd4) && b != 16'd0)) ? 17 : 1;
  endfunction

  // Driver: issue one command at a negedge, wait for the response, hold it
  // for `stall` cycles, then complete the handshake. lat = -1 on timeout.
  task automatic run_cmd(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                         input logic use_acc, input int stall,
                         output int lat, output logic [31:0] d, output logic [1:0] e,
                         output int unstable);
    int w;
    lat = -1; d = '0; e = '0; unstable = 0;
    w = 0;
    while (!cmd_ready && w < 40) begin @(negedge clk); w++; end
    if (!cmd_ready) return;
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_acc = use_acc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 40) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin lat = -1; return; end
    d = rsp_data; e = rsp_err;
    repeat (stall) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== d || rsp_err !== e || cmd_ready !== 1'b0) unstable++;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cmd_valid = 1'b1; cmd_op = 4'd0; cmd_a = 16'd1; cmd_b = 16'd2;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0 ||
        rsp_data !== 32'd0 || rsp_err !== 2'b00) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b busy=%b data=%h err=%b want 0 0 0 0 00",
               cmd_ready, rsp_valid, busy, rsp_data, rsp_err);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready: got=%b want=1", cmd_ready);
    end
    acc_m = 32'd0;
  endtask

  task automatic test_add();
    int lat, u; logic [31:0] d; logic [1:0] e;
    run_cmd(4'd0, 16'd11, 16'd15, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== 32'd26 || e !== 2'b00 || lat !== 1) begin
      bad++; $display("FAIL add_11_15: data=%0d err=%b lat=%0d want 26 00 1", d, e, lat);
    end
    acc_m = 32'd26;
    run_cmd(4'd14, 16'd0, 16'd0, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== acc_m || e !== 2'b00) begin
      bad++; $display("FAIL add_acc: data=%0d err=%b want %0d 00", d, e, acc_m);
    end
  endtask

  task automatic test_mul_chain();
    int lat, u; logic [31:0] d; logic [1:0] e;
    run_cmd(4'd2, 16'd32000, 16'd16000, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== 32'd512000000 || e !== 2'b00 || lat !== 17) begin
      bad++; $display("FAIL mul_32000_16000: data=%0d err=%b lat=%0d want 512000000 00 17", d, e, lat);
    end
    acc_m = 32'd512000000;
    run_cmd(4'd14, 16'd0, 16'd0, 1'b1, 0, lat, d, e, u);
    total++;
    if (d !== 32'd512000000 || e !== 2'b00 || lat !== 1) begin
      bad++; $display("FAIL mul_chain_acc: data=%0d err=%b lat=%0d want 512000000 00 1", d, e, lat);
    end
  endtask

  task automatic test_sub_divzero();
    int lat, u; logic [31:0] d; logic [1:0] e; logic [31:0] acc_before;
    run_cmd(4'd1, 16'd11, 16'd15, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== 32'hFFFFFFFC || e !== 2'b01 || lat !== 1) begin
      bad++; $display("FAIL sub_11_15: data=%h err=%b lat=%0d want fffffffc 01 1", d, e, lat);
    end
    acc_before = acc_m;
    run_cmd(4'd3, 16'd11, 16'd0, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== 32'd0 || e !== 2'b10 || lat !== 1) begin
      bad++; $display("FAIL div_by_zero: data=%0d err=%b lat=%0d want 0 10 1", d, e, lat);
    end
    run_cmd(4'd14, 16'd0, 16'd0, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== acc_before) begin
      bad++; $display("FAIL div_zero_acc_hold: acc=%h want %h", d, acc_before);
    end
    acc_m = acc_before;
  endtask

  task automatic test_backpressure();
    int lat, u; logic [31:0] d; logic [1:0] e;
    run_cmd(4'd4, 16'd32000, 16'd16000, 1'b0, 5, lat, d, e, u);
    total++;
    if (d !== 32'd0 || e !== 2'b00 || lat !== 17) begin
      bad++; $display("FAIL mod_32000_16000: data=%0d err=%b lat=%0d want 0 00 17", d, e, lat);
    end
    total++;
    if (u !== 0) begin
      bad++; $display("FAIL backpressure_stable: unstable_cycles=%0d want 0", u);
    end
    total++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      bad++; $display("FAIL backpressure_release: ready=%b valid=%b want 1 0", cmd_ready, rsp_valid);
    end
    acc_m = 32'd0;
  endtask

  task automatic test_reset_mid();
    int lat, u, seen; logic [31:0] d; logic [1:0] e;
    cmd_valid = 1'b1; cmd_op = 4'd3; cmd_a = 16'd100; cmd_b = 16'd7; cmd_use_acc = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (8) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++; $display("FAIL reset_mid_busy: busy=%b want 1", busy);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b0 || rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_mid_held: ready=%b valid=%b busy=%b want 0 0 0", cmd_ready, rsp_valid, busy);
    end
    rst = 1'b0;
    #1;
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_ready: got=%b want=1", cmd_ready);
    end
    seen = 0;
    repeat (20) begin @(negedge clk); if (rsp_valid !== 1'b0) seen++; end
    total++;
    if (seen !== 0) begin
      bad++; $display("FAIL reset_mid_no_rsp: valid_cycles=%0d want 0", seen);
    end
    acc_m = 32'd0;
    run_cmd(4'd14, 16'd0, 16'd0, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== 32'd0) begin
      bad++; $display("FAIL reset_mid_acc: acc=%0d want 0", d);
    end
    run_cmd(4'd3, 16'd100, 16'd7, 1'b0, 0, lat, d, e, u);
    total++;
    if (d !== 32'd14 || e !== 2'b00 || lat !== 17) begin
      bad++; $display("FAIL reset_mid_redo_div: data=%0d err=%b lat=%0d want 14 00 17", d, e, lat);
    end
    acc_m = 32'd14;
  endtask

  task automatic test_random();
    int lat, u, exp_lat;
    logic [31:0] d; logic [1:0] e;
    logic [3:0] op; logic [15:0] a, b, a_eff; logic use_acc; logic [33:0] exp_v;
    for (int i = 0; i < 60; i++) begin
      op      = 4'($urandom_range(0, 15));
      a       = 16'($urandom);
      b       = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(0, 65535) >> $urandom_range(0, 12));
      if (op == 4'd2 && b == 16'd0) b = 16'd1;
      use_acc = 1'($urandom_range(0, 1));
      a_eff   = use_acc ? acc_m[15:0] : a;
      exp_v   = ref_result(op, a_eff, b, acc_m);
      exp_lat = ref_latency(op, b);
      run_cmd(op, a, b, use_acc, $urandom_range(0, 3), lat, d, e, u);
      total++;
      if (d !== exp_v[31:0] || e !== exp_v[33:32] || lat !== exp_lat || u !== 0) begin
        bad++;
        $display("FAIL random_%0d op=%0d a=%h b=%h: data=%h err=%b lat=%0d unstable=%0d want %h %b %0d 0",
                 i, op, a_eff, b, d, e, lat, u, exp_v[31:0], exp_v[33:32], exp_lat);
      end
      if (exp_v[33:32] == 2'b00) acc_m = exp_v[31:0];
    end
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_use_acc = 1'b0; rsp_ready = 1'b0; acc_m = '0;
    @(negedge clk);
    test_reset();
    test_add();
    test_mul_chain();
    test_sub_divzero();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, operand width; all requirements below assume 16.
REQ-002 clk  input  1  rising-edge clock, the only clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 cmd_valid  input  1  command present.
REQ-005 cmd_ready  output  1  block accepts a command this cycle.
REQ-006 cmd_op  input  4  opcode, as defined in REQ-012.
REQ-007 cmd_a  input  16  operand A, unsigned.
REQ-008 cmd_b  input  16  operand B, unsigned.
REQ-009 cmd_use_acc  input  1  substitute acc[15:0] for cmd_a.
REQ-010 rsp_valid / rsp_ready  output / input  1 / 1  response handshake.
REQ-011 rsp_data  output  32  result; rsp_err  output  2  ([0] carry/borrow, [1] divide-by-zero or illegal op); busy  output  1  state != IDLE.

Function
REQ-012 Opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 mod, 5 and, 6 or, 7 nand, 8 nor, 9 xor, 10 xnor, 11 not A, 12 all-ones, 13 zero, 14 pass acc, 15 illegal.
REQ-013 FSM states: IDLE, ITER, RESP. cmd_ready = (state==IDLE).
REQ-014 Command accepted on a clock edge with cmd_valid & cmd_ready; operands and op are latched at that edge.
REQ-015 Single-cycle ops (0,1,5-15) and div/mod with B==0: IDLE->RESP; rsp_valid high the cycle after acceptance (latency 1).
REQ-016 mul/div/mod with B!=0: IDLE->ITER; run exactly 16 iterations, one per cycle (shift-add multiply, restoring divide); then ->RESP. rsp_valid high 17 cycles after acceptance.
REQ-017 RESP: rsp_valid=1; rsp_data and rsp_err stay stable until rsp_valid & rsp_ready; then ->IDLE. No command is accepted in the same cycle as a response handshake.
REQ-018 add: rsp_data = zero-extended 17-bit sum; rsp_err[0] = bit 16 of the sum.
REQ-019 sub: rsp_data = A-B sign-extended to 32 bits; rsp_err[0] = (A<B).
REQ-020 mul: rsp_data = full 32-bit unsigned product; err = 00.
REQ-021 div: rsp_data = zero-extended floor(A/B). mod: rsp_data = zero-extended A mod B. With B==0: rsp_data=0, rsp_err=10.
REQ-022 Logic ops are bitwise on 16 bits and zero-extended; not ignores B.
REQ-023 Op 15: rsp_data=0, rsp_err=10.
REQ-024 acc (32 bits) loads rsp_data on entry to RESP only when the result's err==00; otherwise it holds its value. Op 14 returns acc unchanged.
REQ-025 rsp_err[0] is 0 for every op other than add and sub.

Reset
REQ-026 When rst=1 at an edge, in any state (including mid-ITER): state=IDLE, acc=0, rsp_valid=0, rsp_data=0, rsp_err=00, iteration counter=0; any in-flight command is discarded.
REQ-027 While rst=1, cmd_ready=0 and no command is accepted. cmd_ready=1 in the first cycle after rst is deasserted.

Verification
REQ-028 Add: add A=11, B=15 -> rsp_data=26, err=00, rsp_valid one cycle after acceptance; acc=26.
REQ-029 Multiply and chain: mul A=32000, B=16000 -> 512000000, err=00, exactly 17 cycles after acceptance. Then use_acc=1, op 14 -> 512000000.
REQ-030 Subtract and divide-by-zero: sub 11-15 -> 0xFFFFFFFC, err=01. div 11/0 -> data=0, err=10, latency 1, acc unchanged.
REQ-031 Backpressure: hold rsp_ready=0 for 5 cycles during mod 32000%16000 -> data=0 stays stable, cmd_ready=0; on release, handshake completes and cmd_ready=1 the next cycle.
REQ-032 Reset mid-operation: assert rst at iteration 8 of div 100/7 -> rsp_valid never rises, acc=0, cmd_ready=1 the cycle after rst drops; a new div 100/7 then returns 14.
